// File: rtl/prog_seq_if.sv
// prog_seq_if: control, table-programming and output bundle for
// prog_sequence_counter.
//   master : drives start/enable/mode, table writes (wr_en/wr_addr/wr_data)
//            and length writes (len_wr/len_data); observes the outputs.
//   slave  : the counter; returns seq_out, seq_idx, valid, done, wrap.
interface prog_seq_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  logic             enable;
  logic [1:0]       mode;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             len_wr;
  logic [AW:0]      len_data;
  logic [WIDTH-1:0] seq_out;
  logic [AW-1:0]    seq_idx;
  logic             valid;
  logic             done;
  logic             wrap;

  modport master (
    output start, enable, mode, wr_en, wr_addr, wr_data, len_wr, len_data,
    input  seq_out, seq_idx, valid, done, wrap
  );

  modport slave (
    input  start, enable, mode, wr_en, wr_addr, wr_data, len_wr, len_data,
    output seq_out, seq_idx, valid, done, wrap
  );
endinterface

// File: rtl/prog_sequence_counter.sv
// prog_sequence_counter: emits a programmable sequence of WIDTH-bit codes
// from a DEPTH-entry table, one code per enabled clock, in repeat, one-shot
// or ping-pong mode.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : prog_seq_if slave (control, table/length writes, outputs)
module prog_sequence_counter #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic     clock,
  input  logic     reset,
  prog_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [LW-1:0]    len;
  logic [AW-1:0]    idx;
  logic             dir_down;
  logic [WIDTH-1:0] seq_out_q;
  logic             valid_q;
  logic             done_q;
  logic             wrap_q;

  // Next-step decode, evaluated against the length currently in force
  logic [LW-1:0]    len_m1;
  logic [LW-1:0]    len_m2;
  logic             at_end;
  logic             past_end;
  logic [AW-1:0]    n_idx;
  logic             n_dir_down;
  logic             n_wrap;
  logic             n_done;
  logic             step;
  logic [WIDTH-1:0] code_step;
  logic [WIDTH-1:0] code_zero;
  logic [LW-1:0]    len_new;

  assign len_m1   = len - LW'(1);
  assign len_m2   = len - LW'(2);
  // Comparisons use >= so a length shrunk below idx behaves as end-of-sequence
  assign at_end   = ({1'b0, idx} >= len_m1);
  assign past_end = ({1'b0, idx} >= len);
  assign step     = (state == RUN) && bus.enable && !bus.start;

  always_comb begin
    n_idx      = idx;
    n_dir_down = 1'b0;
    n_wrap     = 1'b0;
    n_done     = 1'b0;
    case (bus.mode)
      2'd1: begin
        if (at_end) begin
          n_wrap = 1'b1;
          n_done = 1'b1;
        end else begin
          n_idx = idx + AW'(1);
        end
      end
      2'd2: begin
        if (len == LW'(1)) begin
          n_idx  = '0;
          n_wrap = 1'b1;
        end else if (!dir_down || past_end) begin
          if (at_end) begin
            n_idx      = len_m2[AW-1:0];
            n_dir_down = 1'b1;
            n_wrap     = 1'b1;
          end else begin
            n_idx = idx + AW'(1);
          end
        end else begin
          if (idx == '0) begin
            n_idx  = AW'(1);
            n_wrap = 1'b1;
          end else begin
            n_idx      = idx - AW'(1);
            n_dir_down = 1'b1;
          end
        end
      end
      default: begin
        if (at_end) begin
          n_idx  = '0;
          n_wrap = 1'b1;
        end else begin
          n_idx = idx + AW'(1);
        end
      end
    endcase
  end

  // A write landing on the index being fetched this edge is forwarded
  assign code_step = (bus.wr_en && (bus.wr_addr == n_idx)) ? bus.wr_data : tbl[n_idx];
  assign code_zero = (bus.wr_en && (bus.wr_addr == '0))    ? bus.wr_data : tbl[0];

  // Zero-length writes are dropped; oversize lengths saturate to DEPTH
  assign len_new = (bus.len_data > LW'(DEPTH)) ? LW'(DEPTH) : bus.len_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= WIDTH'(i);
      len       <= LW'(DEPTH);
      idx       <= '0;
      dir_down  <= 1'b0;
      state     <= IDLE;
      seq_out_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.wr_en) tbl[bus.wr_addr] <= bus.wr_data;
      if (bus.len_wr && (bus.len_data != '0)) len <= len_new;
      // Direction only has meaning in ping-pong; outside it, it rests at up
      if (bus.mode != 2'd2) dir_down <= 1'b0;
      if (bus.start) begin
        state     <= RUN;
        idx       <= '0;
        dir_down  <= 1'b0;
        seq_out_q <= code_zero;
        valid_q   <= 1'b1;
        done_q    <= 1'b0;
      end else if (step) begin
        idx       <= n_idx;
        dir_down  <= n_dir_down;
        seq_out_q <= code_step;
        wrap_q    <= n_wrap;
        if (n_done) begin
          state   <= DONE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.seq_out = seq_out_q;
  assign bus.seq_idx = idx;
  assign bus.valid   = valid_q;
  assign bus.done    = done_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_prog_sequence_counter.sv
module tb_prog_sequence_counter;
  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  prog_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  prog_sequence_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int out;
    int idx;
    int vld;
    int dn;
    int wr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: spec-level state held as plain integers
  int m_tbl[DEPTH];
  int m_len, m_idx, m_dir, m_state, m_out, m_wrap;  // m_state 0 idle 1 run 2 done
  int cur_mode = 0;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % (1 << WIDTH);
    m_len = DEPTH; m_idx = 0; m_dir = 1; m_state = 0; m_out = 0; m_wrap = 0;
  endfunction

  function automatic int fetch(int a, int we, int wa, int wd);
    return (we != 0 && wa == a) ? wd : m_tbl[a];
  endfunction

  function automatic void model_clock(int s, int en, int md, int we, int wa,
                                      int wd, int lw, int ld);
    int m;
    m_wrap = 0;
    m = (md == 3) ? 0 : md;
    if (s != 0) begin
      m_idx = 0; m_dir = 1; m_state = 1; m_out = fetch(0, we, wa, wd);
    end else if (m_state == 1 && en != 0) begin
      if (m == 0) begin
        if (m_idx >= m_len - 1) begin m_idx = 0; m_wrap = 1; end
        else m_idx++;
      end else if (m == 1) begin
        if (m_idx >= m_len - 1) begin m_wrap = 1; m_state = 2; end
        else m_idx++;
      end else begin
        if (m_len == 1) begin
          m_idx = 0; m_dir = 1; m_wrap = 1;
        end else if (m_dir == 1 || m_idx >= m_len) begin
          if (m_idx >= m_len - 1) begin m_dir = -1; m_idx = m_len - 2; m_wrap = 1; end
          else m_idx++;
        end else begin
          if (m_idx == 0) begin m_dir = 1; m_idx = 1; m_wrap = 1; end
          else m_idx--;
        end
      end
      m_out = fetch(m_idx, we, wa, wd);
    end
    if (m != 2) m_dir = 1;
    if (we != 0) m_tbl[wa] = wd;
    if (lw != 0 && ld != 0) m_len = (ld > DEPTH) ? DEPTH : ld;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.out = m_out; e.idx = m_idx; e.vld = (m_state == 1) ? 1 : 0;
    e.dn = (m_state == 2) ? 1 : 0; e.wr = m_wrap;
    return e;
  endfunction

  task automatic drive(input int s, input int en, input int md, input int we,
                       input int wa, input int wd, input int lw, input int ld);
    @(negedge clock);
    bus.start    = s[0];
    bus.enable   = en[0];
    bus.mode     = md[1:0];
    bus.wr_en    = we[0];
    bus.wr_addr  = wa[AW-1:0];
    bus.wr_data  = wd[WIDTH-1:0];
    bus.len_wr   = lw[0];
    bus.len_data = ld[AW:0];
    if (reset == 1'b0) model_reset();
    else model_clock(s, en, md, we, wa, wd, lw, ld);
    exp_q.push_back(snapshot());
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, cur_mode, 0, 0, 0, 0, 0);
  endtask
  task automatic start_seq();
    drive(1, 0, cur_mode, 0, 0, 0, 0, 0);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, cur_mode, 0, 0, 0, 0, 0);
  endtask
  task automatic wr_tbl(input int a, input int d);
    drive(0, 0, cur_mode, 1, a, d, 0, 0);
  endtask
  task automatic wr_len(input int l);
    drive(0, 0, cur_mode, 0, 0, 0, 1, l);
  endtask

  // One enabled step followed by a direct comparison against a literal code
  task automatic step_lit(input string nm, input int code, input int wr);
    drive(0, 1, cur_mode, 0, 0, 0, 0, 0);
    @(posedge clock); #2;
    checks++;
    if (int'(bus.seq_out) != code || int'(bus.wrap) != wr) begin
      errors++;
      $display("FAIL %s: seq_out=%0d wrap=%0d, required seq_out=%0d wrap=%0d",
               nm, bus.seq_out, bus.wrap, code, wr);
    end
  endtask

  // Monitor: pops one expectation per clock and compares the full output set
  initial begin
    forever begin
      @(posedge clock); #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (int'(bus.seq_out) != e.out || int'(bus.seq_idx) != e.idx ||
            int'(bus.valid) != e.vld || int'(bus.done) != e.dn ||
            int'(bus.wrap) != e.wr) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got out=%0d idx=%0d valid=%0d done=%0d wrap=%0d, required out=%0d idx=%0d valid=%0d done=%0d wrap=%0d",
                   $time, bus.seq_out, bus.seq_idx, bus.valid, bus.done, bus.wrap,
                   e.out, e.idx, e.vld, e.dn, e.wr);
        end
      end
    end
  end

  initial begin
    bus.start = 0; bus.enable = 0; bus.mode = 0; bus.wr_en = 0; bus.wr_addr = 0;
    bus.wr_data = 0; bus.len_wr = 0; bus.len_data = 0;
    model_reset();
    idle_cyc(2);
    @(negedge clock); reset = 1'b1;

    // Default table, repeat mode
    cur_mode = 0;
    start_seq();
    for (int i = 1; i < 8; i++) step_lit("default_seq", i, 0);
    step_lit("default_wrap", 0, 1);

    // Programmed table 0,1,2,3,6,5,7 with length 7
    wr_tbl(4, 6); wr_tbl(6, 7); wr_len(7);
    start_seq();
    run(14);

    // One-shot: stops at idx 6, ignores enable, restarts on start
    cur_mode = 1;
    start_seq();
    run(10);
    start_seq();
    run(2);

    // Ping-pong on identity table with len 4, then len 1
    cur_mode = 2;
    wr_tbl(4, 4); wr_tbl(6, 6); wr_len(4);
    start_seq();
    step_lit("pp_1", 1, 0); step_lit("pp_2", 2, 0); step_lit("pp_3", 3, 0);
    step_lit("pp_turn_hi", 2, 1); step_lit("pp_1d", 1, 0); step_lit("pp_0d", 0, 0);
    step_lit("pp_turn_lo", 1, 1); step_lit("pp_2u", 2, 0);
    wr_len(1);
    step_lit("pp_len1_a", 0, 1); step_lit("pp_len1_b", 0, 1);
    run(2);

    // Length corner cases and write bypass in repeat mode
    cur_mode = 0;
    wr_len(0);
    wr_len(15);
    start_seq();
    run(2);
    drive(0, 1, 0, 1, 3, 5, 0, 0);
    run(8);
    // start together with enable
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    run(4);

    // Async reset mid-run at idx 4
    wr_tbl(3, 3);
    start_seq();
    run(4);
    @(negedge clock); #1;
    reset = 1'b0; #1;
    checks++;
    if (bus.seq_out != 0 || bus.seq_idx != 0 || bus.valid != 0 || bus.done != 0 || bus.wrap != 0) begin
      errors++;
      $display("FAIL async_reset: out=%0d idx=%0d valid=%0d done=%0d wrap=%0d, required all 0",
               bus.seq_out, bus.seq_idx, bus.valid, bus.done, bus.wrap);
    end
    idle_cyc(2);
    @(negedge clock); reset = 1'b1;
    start_seq();
    run(9);

    // Randomised phase
    for (int i = 0; i < 400; i++) begin
      int s, en, md, we, lw;
      s  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      en = ($urandom_range(0, 3) != 0) ? 1 : 0;
      md = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : cur_mode;
      cur_mode = md;
      we = ($urandom_range(0, 5) == 0) ? 1 : 0;
      lw = ($urandom_range(0, 11) == 0) ? 1 : 0;
      drive(s, en, md, we, int'($urandom_range(0, DEPTH - 1)),
            int'($urandom_range(0, (1 << WIDTH) - 1)), lw, int'($urandom_range(0, 15)));
    end

    idle_cyc(1);
    @(posedge clock); #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_sequence_counter.md
Name: prog_sequence_counter

Overview:
- Parametrised successor to the fixed-pattern sequence counter.
- Emits a programmable sequence of WIDTH-bit codes from an internal DEPTH-entry table, one code per enabled clock.
- Sequence length and contents are writable at runtime.
- Supports three modes: repeat, one-shot and ping-pong.
- Sits in the stimulus/pattern generation path and drives downstream datapaths or test logic.

Parameters:
WIDTH, 3, bit width of each sequence code and of seq_out
DEPTH, 8, number of table entries and maximum sequence length (power of two, >=2)
AW, $clog2(DEPTH), index/address width (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  pulse: restart sequence at index 0
enable  input  1  advance one step per cycle while RUN
mode  input  2  0=repeat, 1=one-shot, 2=ping-pong, 3=treated as repeat
wr_en  input  1  table write strobe
wr_addr  input  AW  table write address
wr_data  input  WIDTH  table write data
len_wr  input  1  length register write strobe
len_data  input  AW+1  new sequence length
seq_out  output  WIDTH  current code, registered
seq_idx  output  AW  current table index
valid  output  1  high while state=RUN
done  output  1  high while state=DONE
wrap  output  1  one-cycle pulse on wrap or ping-pong turnaround

Behaviour:
- Reset (reset=0, async):
  - table[i] <= i mod 2^WIDTH; len <= DEPTH; idx <= 0; dir <= up.
  - state <= IDLE.
  - seq_out=0, seq_idx=0, valid=0, done=0, wrap=0.
- States IDLE, RUN, DONE:
  - start from any state -> RUN with idx<=0, dir<=up, seq_out<=table[0].
  - start has priority over enable in the same cycle.
- RUN, enable=1: one step per clock. Next index by mode:
  - Repeat: idx==len-1 (or idx>=len after a shrink) -> 0 with wrap=1; else idx+1.
  - One-shot: idx==len-1 (or beyond) -> hold idx, state DONE, wrap=1 for that cycle; else idx+1.
  - Ping-pong, dir up: idx>=len-1 -> dir<=down, idx<=len-2, wrap=1.
  - Ping-pong, dir down: idx==0 -> dir<=up, idx<=1, wrap=1.
  - Ping-pong with len=1: idx stays 0 and wrap pulses every step.
- RUN, enable=0: outputs hold, wrap=0.
- IDLE and DONE ignore enable; seq_out and seq_idx hold.
- Output timing:
  - seq_out <= table[next_idx] in the same edge as idx <= next_idx, so seq_out always shows the code at seq_idx.
  - Latency from start to seq_out=table[0] is 1 clock.
- Mode may change mid-run; it takes effect at the next step. dir is meaningful only in ping-pong and is forced to up when leaving ping-pong.
- Table writes are allowed in any state.
  - If a step's next_idx equals wr_addr in the same cycle, seq_out takes wr_data (write bypass).
  - A write to the current idx without a step does not change seq_out until that index is revisited.
- len_wr:
  - len_data==0 is ignored.
  - len_data>DEPTH clamps to DEPTH.
  - The new length takes effect on the next step.
  - If idx>=new len, the next step behaves as end-of-sequence for the mode.
- wrap is a registered one-cycle pulse, aligned with the edge that produces the wrapped/turned index.
- Reset asserted mid-sequence returns everything to reset values immediately; the programmed table and len are lost.

Test Plan:
- Reset, start, enable=1, mode=0, default table -> seq_out 0,1,2,...,7,0 with wrap=1 on the 7->0 step; valid=1 throughout.
- Program table 0..6 = 0,1,2,3,6,5,7, len=7, mode=0, start, run 15 cycles -> 0,1,2,3,6,5,7,0,1,2,3,6,5,7,0 with wrap pulses at both 7->0 steps.
- Same table, mode=1 -> sequence stops at 7 with seq_idx=6, done=1, valid=0; further enable changes nothing; start returns seq_out=0 and valid=1.
- Mode=2, len=4, identity table -> 0,1,2,3,2,1,0,1,2; wrap at 3->2 and 0->1; then len=1 -> seq_out stays 0 and wrap pulses every cycle.
- Corner cases:
  - Write 5 to the upcoming index during its step -> seq_out=5 that cycle.
  - len_data=0 -> no change.
  - len_data=15 (DEPTH=8) -> len reads as 8.
  - start and enable together -> seq_out=table[0].
- Assert reset mid-run at idx=4 -> outputs 0 asynchronously; after release, start yields the identity sequence again.
